aes_round_engine: RTL and testbench

Iterative AES block cipher core with a valid/ready handshake on both sides. It is the parametrised successor to the single-round cipher: AES-128/192/256 are selected per block, and 1 or 2 rounds execute per clock. With the decrypt feature compiled in, it also runs the inverse cipher. It sits between the SPI framing logic and the key-expansion block, and consumes the same flat round-key bus, `w`.

---
 rtl/aes_round_engine.sv | 267 ++++++++++++++++++++++++++
 tb/tb_aes_round_engine.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 cipher, UNROLL rounds per clock.
// Ports: clk, rst_n; in_valid/in_ready/in_data/nr/dec in; w round keys;
// out_valid/out_ready/out_data/out_err out. AES_ENGINE_DECRYPT_EN adds
// the inverse cipher.
module aes_round_engine #(
  parameter int UNROLL = 1,
  parameter int NR_MAX = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              in_data,
  input  logic [3:0]                nr,
  input  logic                      dec,
  input  logic [128*(NR_MAX+1)-1:0] w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              out_data,
  output logic                      out_err
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("aes_round_engine: UNROLL must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] STEP = 4'(UNROLL);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] a,
    input int         n
  );
    return (a << n) | (a >> (8 - n));
  endfunction

  // a^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
    return gmul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = ginv(a);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3)
             ^ rotl(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] bt(
    input logic [127:0] s,
    input int           i
  );
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(bt(s, r + 4*((c+r)%4)));
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = bt(s, 4*c + r);
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4])
                              ^ a[(r+1)%4] ^ a[(r+2)%4]
                              ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [127:0] t;
    t = sub_shift(s);
    if (!last) t = mix(t);
    return t ^ k;
  endfunction

`ifdef AES_ENGINE_DECRYPT_EN
  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] ishift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] =
          isbox(bt(s, r + 4*((c-r+4)%4)));
    return o;
  endfunction

  function automatic logic [127:0] imix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = bt(s, 4*c + r);
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e)
                              ^ gmul(a[(r+1)%4], 8'h0b)
                              ^ gmul(a[(r+2)%4], 8'h0d)
                              ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  function automatic logic [127:0] dec_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [127:0] t;
    t = ishift_sub(s) ^ k;
    if (!last) t = imix(t);
    return t;
  endfunction
`endif

  logic [127:0] rk [NR_MAX+1];

  for (genvar k = 0; k <= NR_MAX; k++) begin : g_rk
    assign rk[k] = w[128*k +: 128];
  end

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   nr_q, nr_d;
  logic         dec_q, dec_d;
  logic         err_q, err_d;
  logic         dec_acc;
  logic         legal;

`ifdef AES_ENGINE_DECRYPT_EN
  assign dec_acc = dec;
`else
  logic dec_unused;
  assign dec_unused = dec;
  assign dec_acc    = 1'b0;
`endif

  assign legal = (nr == 4'd10 || nr == 4'd12 || nr == 4'd14)
              && (int'(nr) <= NR_MAX);

  logic [127:0] st_a, st_b, st_nx;
  logic [3:0]   r1;
  logic         fin;

  // st_b is the second round of a cycle; only used when UNROLL=2
  always_comb begin
    r1   = rnd_q + 4'd1;
    st_a = enc_round(st_q, rk[rnd_q], rnd_q == nr_q);
    st_b = enc_round(st_a, rk[r1], r1 == nr_q);
    fin  = (UNROLL == 1) ? (rnd_q == nr_q) : (r1 == nr_q);
`ifdef AES_ENGINE_DECRYPT_EN
    if (dec_q) begin
      r1   = rnd_q - 4'd1;
      st_a = dec_round(st_q, rk[rnd_q], rnd_q == 4'd0);
      st_b = dec_round(st_a, rk[r1], r1 == 4'd0);
      fin  = (UNROLL == 1) ? (rnd_q == 4'd0) : (rnd_q == 4'd1);
    end
`endif
    st_nx = (UNROLL == 1) ? st_a : st_b;
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rnd_d   = rnd_q;
    nr_d    = nr_q;
    dec_d   = dec_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          nr_d  = nr;
          dec_d = dec_acc;
          err_d = !legal;
          if (!legal) begin
            st_d    = '0;
            rnd_d   = '0;
            state_d = DONE;
          end else if (dec_acc) begin
            st_d    = in_data ^ rk[nr];
            rnd_d   = nr - 4'd1;
            state_d = ROUND;
          end else begin
            st_d    = in_data ^ rk[0];
            rnd_d   = 4'd1;
            state_d = ROUND;
          end
        end
      end
      ROUND: begin
        st_d  = st_nx;
        rnd_d = dec_q ? rnd_q - STEP : rnd_q + STEP;
        if (fin) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rnd_q   <= '0;
      nr_q    <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? st_q : '0;
  assign out_err   = out_valid & err_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: UNROLL=1 and UNROLL=2 instances against
// a byte-matrix AES model with its own key schedule and S-box search.
module tb_aes_round_engine;

  localparam int NRM = 14;
  localparam int WW  = 128*(NRM+1);

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    in_valid, in_ready, out_valid, out_ready, out_err;
  logic [127:0]  in_data;
  logic [3:0]    nr;
  logic          dec;
  logic [WW-1:0] w;
  logic [127:0]  out_data [2];

  int n_chk = 0;
  int n_pass = 0;

  aes_round_engine #(.UNROLL(1), .NR_MAX(NRM)) u_eng1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .nr(nr), .dec(dec), .w(w),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_err(out_err[0])
  );

  aes_round_engine #(.UNROLL(2), .NR_MAX(NRM)) u_eng2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .nr(nr), .dec(dec), .w(w),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_err(out_err[1])
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] want
  );
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] mrk [NRM+1];
  logic [7:0]   ms  [4][4];

  // carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int n);
    logic [31:0] kw [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk = n - 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(n+1); i++) begin
      if (i < nk) kw[i] = key[255-32*i -: 32];
      else begin
        t = kw[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        kw[i] = kw[i-nk] ^ t;
      end
    end
    for (int k = 0; k <= NRM; k++) begin
      if (k <= n) begin
        mrk[k] = {kw[4*k], kw[4*k+1], kw[4*k+2], kw[4*k+3]};
        w[128*k +: 128] = mrk[k];
      end else
        w[128*k +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic add_key(input int k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ms[r][c] = ms[r][c] ^ mrk[k][127-8*(r+4*c) -: 8];
  endtask

  // column times the circulant matrix {02,03,01,01} or {0e,0b,0d,09}
  task automatic mix_cols(input bit inv);
    logic [7:0] kf [4];
    logic [7:0] a  [4];
    if (inv) kf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     kf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = ms[r][c];
      for (int r = 0; r < 4; r++) begin
        ms[r][c] = 8'h00;
        for (int j = 0; j < 4; j++)
          ms[r][c] = ms[r][c] ^ gm(a[(r+j)%4], kf[j]);
      end
    end
  endtask

  task automatic model(
    input  logic [127:0] blk,
    input  int           n,
    input  bit           dv,
    output logic [127:0] res
  );
    logic [7:0] t [4][4];
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ms[r][c] = blk[127-8*(r+4*c) -: 8];
    if (!dv) begin
      add_key(0);
      for (int rd = 1; rd <= n; rd++) begin
        t = ms;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            ms[r][c] = sb[t[r][(c+r)%4]];
        if (rd < n) mix_cols(1'b0);
        add_key(rd);
      end
    end else begin
      add_key(n);
      for (int rd = n - 1; rd >= 0; rd--) begin
        t = ms;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            ms[r][(c+r)%4] = isb[t[r][c]];
        add_key(rd);
        if (rd > 0) mix_cols(1'b1);
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(r+4*c) -: 8] = ms[r][c];
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] kat_key(input int nb);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < nb; i++) k[255-8*i -: 8] = 8'(i);
    return k;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(
    input  int           u,
    input  logic [127:0] d,
    input  int           n,
    input  bit           dv,
    input  int           stall,
    output logic [127:0] res,
    output logic         er,
    output int           lat
  );
    @(negedge clk);
    in_data     = d;
    nr          = 4'(n);
    dec         = dv;
    in_valid[u] = 1'b1;
    check("in_ready_idle", in_ready[u], 1'b1);
    @(negedge clk);
    in_valid[u] = 1'b0;
    lat = 1;
    while (!out_valid[u] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid[u], 1'b1);
    repeat (stall) @(negedge clk);
    res          = out_data[u];
    er           = out_err[u];
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check("idle_after_hs", in_ready[u], 1'b1);
  endtask

  task automatic do_vec(
    input  int           u,
    input  logic [255:0] key,
    input  logic [127:0] d,
    input  int           n,
    input  bit           dv,
    input  int           stall,
    output logic [127:0] res
  );
    logic [127:0] want;
    logic         er;
    int           lat, lexp;
    bit           legal, dv_eff;
    legal = (n == 10 || n == 12 || n == 14);
`ifdef AES_ENGINE_DECRYPT_EN
    dv_eff = dv;
`else
    dv_eff = 1'b0;
`endif
    if (legal) begin
      expand(key, n);
      model(d, n, dv_eff, want);
      lexp = n / (u + 1) + 1;
    end else begin
      want = '0;
      lexp = 1;
    end
    run_block(u, d, n, dv, stall, res, er, lat);
    check("data", res, want);
    check("err", er, !legal);
    check("latency", lat, lexp);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] res;
    int           lat;
    int           u, n, sel, stall;
    bit           dv;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    nr        = '0;
    dec       = 1'b0;
    w         = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", in_ready[i], 1'b1);
      check("rst_out_valid", out_valid[i], 1'b0);
      check("rst_out_data", out_data[i], 128'h0);
      check("rst_out_err", out_err[i], 1'b0);
    end
    rst_n = 1'b1;

    do_vec(0, kat_key(16), PT, 10, 1'b0, 0, res);
    check("kat128_u1", res, C128);
    do_vec(1, kat_key(24), PT, 12, 1'b0, 2, res);
    check("kat192_u2", res, C192);
    do_vec(1, kat_key(32), PT, 14, 1'b0, 0, res);
    check("kat256_u2", res, C256);
    do_vec(0, kat_key(32), PT, 14, 1'b0, 1, res);
    check("kat256_u1", res, C256);
    do_vec(1, kat_key(16), PT, 10, 1'b0, 0, res);
    check("kat128_u2", res, C128);

    do_vec(0, kat_key(16), C128, 10, 1'b1, 0, res);
`ifdef AES_ENGINE_DECRYPT_EN
    check("kat_dec_u1", res, PT);
`endif
    do_vec(1, kat_key(16), C128, 10, 1'b1, 0, res);
`ifdef AES_ENGINE_DECRYPT_EN
    check("kat_dec_u2", res, PT);
`endif

    do_vec(0, {r128(), r128()}, r128(), 11, 1'b0, 0, res);
    do_vec(1, {r128(), r128()}, r128(), 0, 1'b0, 3, res);
    do_vec(1, {r128(), r128()}, r128(), 15, 1'b1, 0, res);

    // backpressure: 20-cycle stall in DONE with in_valid pulses
    expand(kat_key(16), 10);
    @(negedge clk);
    in_data     = PT;
    nr          = 4'd10;
    dec         = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    lat = 1;
    while (!out_valid[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 11);
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = i[0];
      in_data     = r128();
      check("bp_valid", out_valid[0], 1'b1);
      check("bp_data", out_data[0], C128);
      check("bp_in_ready", in_ready[0], 1'b0);
      @(negedge clk);
    end
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    check("bp_data_hs", out_data[0], C128);
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("bp_no_accept_hs", in_ready[0], 1'b1);
    check("bp_valid_low", out_valid[0], 1'b0);
    repeat (3) @(negedge clk);
    check("bp_still_idle", in_ready[0], 1'b1);
    check("bp_no_ghost", out_valid[0], 1'b0);

    // reset at cycle 5 of an AES-256 block
    expand(kat_key(32), 14);
    @(negedge clk);
    in_data     = PT;
    nr          = 4'd14;
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", in_ready[1], 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", in_ready[1], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("rst_no_out", out_valid[1], 1'b0);
      check("rst_ready", in_ready[1], 1'b1);
      @(negedge clk);
    end
    do_vec(1, kat_key(32), PT, 14, 1'b0, 0, res);
    check("post_rst_kat", res, C256);

    // randomized blocks
    for (int b = 0; b < 30; b++) begin
      u     = int'($urandom_range(1, 0));
      sel   = int'($urandom_range(7, 0));
      n     = (sel == 0) ? int'($urandom_range(15, 0))
                         : 10 + 2*(sel % 3);
      dv    = 1'($urandom_range(1, 0));
      stall = int'($urandom_range(3, 0));
      do_vec(u, {r128(), r128()}, r128(), n, dv, stall, res);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
